// File: rtl/gcode_tokenizer_pkg.sv
// Shared types for the G-code lexer: token kinds, character classes and
// fixed encodings seen by the downstream command assembler.
package gcode_tokenizer_pkg;

   typedef enum logic [2:0] {
      TOK_G   = 3'd0,
      TOK_X   = 3'd1,
      TOK_Y   = 3'd2,
      TOK_I   = 3'd3,
      TOK_J   = 3'd4,
      TOK_F   = 3'd5,
      TOK_EOL = 3'd6,
      TOK_ERR = 3'd7
   } Tok_t;

   typedef enum logic [2:0] {
      CH_DIGIT = 3'd0,
      CH_WORD  = 3'd1,
      CH_SPACE = 3'd2,
      CH_EOL   = 3'd3,
      CH_MINUS = 3'd4,
      CH_DOT   = 3'd5,
      CH_OTHER = 3'd6
   } Char_t;

endpackage

// File: rtl/gcode_tokenizer_decoder.sv
// Combinational character classifier: maps one ASCII byte to a class,
// its digit value and, for word letters, the token kind it starts.
module gcode_tokenizer_decoder
   import gcode_tokenizer_pkg::*;
(
   input  logic [7:0] ch,
   output Char_t      cls,
   output logic [3:0] digit,
   output Tok_t       word
);

   // Classify the byte; carriage return and tab behave like a space.
   always_comb begin
      cls   = CH_OTHER;
      digit = 4'd0;
      word  = TOK_ERR;
      if (ch >= 8'h30 && ch <= 8'h39) begin
         cls   = CH_DIGIT;
         digit = ch[3:0];
      end else begin
         case (ch)
            8'h47:               begin cls = CH_WORD; word = TOK_G; end // G
            8'h58:               begin cls = CH_WORD; word = TOK_X; end // X
            8'h59:               begin cls = CH_WORD; word = TOK_Y; end // Y
            8'h49:               begin cls = CH_WORD; word = TOK_I; end // I
            8'h4A:               begin cls = CH_WORD; word = TOK_J; end // J
            8'h46:               begin cls = CH_WORD; word = TOK_F; end // F
            8'h20, 8'h09, 8'h0D: cls = CH_SPACE;
            8'h0A:               cls = CH_EOL;
            8'h2D:               cls = CH_MINUS;
            8'h2E:               cls = CH_DOT;
            default:             cls = CH_OTHER;
         endcase
      end
   end

endmodule

// File: rtl/gcode_tokenizer.sv
// Streaming G-code lexer: turns an ASCII byte stream into word tokens with
// signed fixed-point values plus end-of-line tokens, over valid/ready.
module gcode_tokenizer
   import gcode_tokenizer_pkg::*;
#(
   parameter int NUM_BITS       = 32,
   parameter int FRAC_DIGITS    = 2,
   parameter int MAX_INT_DIGITS = 6
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output Tok_t                       out_type,
   output logic signed [NUM_BITS-1:0] out_value,
   output logic                       out_valid,
   input  logic                       out_ready
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_SIGN     = 3'd1;
   localparam logic [2:0] S_INT      = 3'd2;
   localparam logic [2:0] S_FRAC     = 3'd3;
   localparam logic [2:0] S_EMIT     = 3'd4;
   localparam logic [2:0] S_EMIT_EOL = 3'd5;
   localparam logic [2:0] S_SKIP     = 3'd6;

   // Headroom of 4 bits holds acc*10+9 before the range check.
   localparam int             W        = NUM_BITS + 4;
   localparam logic [W-1:0]   ACC_MAX  = {5'b0, {(NUM_BITS-1){1'b1}}};
   localparam logic [7:0]     FRAC_L   = 8'(FRAC_DIGITS);
   localparam logic [7:0]     MAX_INT_L = 8'(MAX_INT_DIGITS);

   logic [2:0]          state_reg, state_next;
   Tok_t                tok_reg, tok_next;
   logic [NUM_BITS-1:0] acc_reg, acc_next;
   logic                neg_reg, neg_next;
   logic                eol_pending_reg, eol_pending_next;
   logic [7:0]          int_cnt_reg, int_cnt_next;
   logic [7:0]          frac_cnt_reg, frac_cnt_next;

   Char_t      cls;
   logic [3:0] digit;
   Tok_t       word;

   gcode_tokenizer_decoder u_decoder (
      .ch    (in_data),
      .cls   (cls),
      .digit (digit),
      .word  (word)
   );

   logic         accept;
   logic         pad_busy;
   logic         acc_ovf;
   logic         err;
   logic [3:0]   mul_digit;
   logic [W-1:0] acc_wide;

   assign in_ready = reset && (state_reg inside {S_IDLE, S_SIGN, S_INT, S_FRAC, S_SKIP});
   assign accept   = in_valid && in_ready;
   // Fraction padding runs in EMIT before the token becomes visible.
   assign pad_busy = (state_reg == S_EMIT) && (tok_reg != TOK_ERR) && (frac_cnt_reg < FRAC_L);

   // Shared x10 (+digit) path; padding multiplies by ten with no digit.
   assign mul_digit = (state_reg == S_EMIT) ? 4'd0 : digit;
   assign acc_wide  = ({4'b0, acc_reg} << 3) + ({4'b0, acc_reg} << 1)
                    + {{(W-4){1'b0}}, mul_digit};
   assign acc_ovf   = acc_wide > ACC_MAX;

   assign out_valid = ((state_reg == S_EMIT) && !pad_busy) || (state_reg == S_EMIT_EOL);
   assign out_type  = (state_reg == S_EMIT_EOL) ? TOK_EOL : tok_reg;
   assign out_value = ((state_reg == S_EMIT) && (tok_reg != TOK_ERR))
                    ? (neg_reg ? -$signed(acc_reg) : $signed(acc_reg)) : '0;

   // Lexer next-state: parse bytes, pad the fraction, hand tokens out.
   always_comb begin
      state_next       = state_reg;
      tok_next         = tok_reg;
      acc_next         = acc_reg;
      neg_next         = neg_reg;
      eol_pending_next = eol_pending_reg;
      int_cnt_next     = int_cnt_reg;
      frac_cnt_next    = frac_cnt_reg;
      err              = 1'b0;
      case (state_reg)
         S_IDLE: if (accept) begin
            case (cls)
               CH_SPACE: ;
               CH_EOL:   state_next = S_EMIT_EOL;
               CH_WORD: begin
                  tok_next         = word;
                  acc_next         = '0;
                  neg_next         = 1'b0;
                  eol_pending_next = 1'b0;
                  int_cnt_next     = 8'd0;
                  frac_cnt_next    = 8'd0;
                  state_next       = S_SIGN;
               end
               default:  err = 1'b1;
            endcase
         end
         S_SIGN: if (accept) begin
            case (cls)
               CH_MINUS: if (neg_reg) err = 1'b1; else neg_next = 1'b1;
               CH_DIGIT: begin
                  acc_next     = {{(NUM_BITS-4){1'b0}}, digit};
                  int_cnt_next = 8'd1;
                  state_next   = S_INT;
               end
               default:  err = 1'b1;
            endcase
         end
         S_INT, S_FRAC: if (accept) begin
            case (cls)
               CH_DIGIT: begin
                  if (state_reg == S_INT) begin
                     if (int_cnt_reg >= MAX_INT_L || acc_ovf) begin
                        err = 1'b1;
                     end else begin
                        acc_next     = acc_wide[NUM_BITS-1:0];
                        int_cnt_next = int_cnt_reg + 8'd1;
                     end
                  end else if (frac_cnt_reg < FRAC_L) begin
                     if (acc_ovf) begin
                        err = 1'b1;
                     end else begin
                        acc_next      = acc_wide[NUM_BITS-1:0];
                        frac_cnt_next = frac_cnt_reg + 8'd1;
                     end
                  end
               end
               CH_DOT:   if (state_reg == S_INT) state_next = S_FRAC; else err = 1'b1;
               CH_SPACE: state_next = S_EMIT;
               CH_EOL: begin
                  state_next       = S_EMIT;
                  eol_pending_next = 1'b1;
               end
               default:  err = 1'b1;
            endcase
         end
         S_EMIT: begin
            if (pad_busy) begin
               if (acc_ovf) begin
                  tok_next = TOK_ERR;
               end else begin
                  acc_next      = acc_wide[NUM_BITS-1:0];
                  frac_cnt_next = frac_cnt_reg + 8'd1;
               end
            end else if (out_ready) begin
               if (eol_pending_reg) begin
                  state_next       = S_EMIT_EOL;
                  eol_pending_next = 1'b0;
               end else if (tok_reg == TOK_ERR) begin
                  state_next = S_SKIP;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         S_EMIT_EOL: if (out_ready) state_next = S_IDLE;
         S_SKIP:     if (accept && cls == CH_EOL) state_next = S_EMIT_EOL;
         default:    state_next = S_IDLE;
      endcase
      // An offending newline still closes the line after the error token.
      if (err) begin
         tok_next         = TOK_ERR;
         state_next       = S_EMIT;
         eol_pending_next = (cls == CH_EOL);
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg       <= S_IDLE;
         tok_reg         <= TOK_ERR;
         acc_reg         <= '0;
         neg_reg         <= 1'b0;
         eol_pending_reg <= 1'b0;
         int_cnt_reg     <= 8'd0;
         frac_cnt_reg    <= 8'd0;
      end else begin
         state_reg       <= state_next;
         tok_reg         <= tok_next;
         acc_reg         <= acc_next;
         neg_reg         <= neg_next;
         eol_pending_reg <= eol_pending_next;
         int_cnt_reg     <= int_cnt_next;
         frac_cnt_reg    <= frac_cnt_next;
      end
   end

endmodule

// File: tb/tb_gcode_tokenizer.sv
// Scoreboard bench for the G-code lexer: expected tokens are queued as
// lines are driven and compared as the lexer hands tokens out.
module tb_gcode_tokenizer;
   import gcode_tokenizer_pkg::*;

   logic               clk = 1'b0;
   logic               reset;
   logic [7:0]         in_data;
   logic               in_valid;
   logic               in_ready;
   Tok_t               out_type;
   logic signed [31:0] out_value;
   logic               out_valid;
   logic               out_ready;

   typedef struct {
      int     t;
      longint v;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   drv_done;

   gcode_tokenizer #(
      .NUM_BITS       (32),
      .FRAC_DIGITS    (2),
      .MAX_INT_DIGITS (6)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_type  (out_type),
      .out_value (out_value),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input Tok_t t, input longint v);
      exp_t e;
      e.t = int'(t);
      e.v = v;
      exp_q.push_back(e);
   endtask

   // Called at a falling edge; returns at a falling edge after acceptance.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check_value("in_ready_wait", longint'(in_ready), 1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_string(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_value("drain", longint'(exp_q.size()), 0);
   endtask

   // Monitor: every accepted token is compared against the queue head.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         $display("tok type=%0d value=%0d", int'(out_type), out_value);
         if (exp_q.size() == 0) begin
            check_value("unexpected_token", longint'(out_type), -1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_value("tok_type", longint'(out_type), longint'(e.t));
            check_value("tok_value", longint'(out_value), e.v);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_value("rst_in_ready", longint'(in_ready), 0);
      check_value("rst_out_valid", longint'(out_valid), 0);
      reset = 1'b1;
      @(negedge clk);
      check_value("post_rst_in_ready", longint'(in_ready), 1);
      check_value("post_rst_out_valid", longint'(out_valid), 0);
      check_value("post_rst_out_type", longint'(out_type), longint'(TOK_ERR));
      check_value("post_rst_out_value", longint'(out_value), 0);

      // Basic line with integer, fraction and negative words.
      push_exp(TOK_G, 100);
      push_exp(TOK_X, 1250);
      push_exp(TOK_Y, -300);
      push_exp(TOK_EOL, 0);
      send_string("G1 X12.5 Y-3\n");

      // Extra fraction digit is truncated.
      push_exp(TOK_X, 12);
      push_exp(TOK_EOL, 0);
      send_string("X0.129\n");

      // Maximum accepted integer digit count.
      push_exp(TOK_F, 12345600);
      push_exp(TOK_EOL, 0);
      send_string("F123456\n");

      // Too many integer digits, then recovery on the next line.
      push_exp(TOK_ERR, 0);
      push_exp(TOK_EOL, 0);
      push_exp(TOK_Y, 100);
      push_exp(TOK_EOL, 0);
      send_string("X9999999\nY1\n");

      // Illegal letter: rest of line skipped.
      push_exp(TOK_ERR, 0);
      push_exp(TOK_EOL, 0);
      send_string("Q5 X1\n");

      // Bare minus, doubled dot, empty line, newline as offender.
      push_exp(TOK_ERR, 0);
      push_exp(TOK_EOL, 0);
      push_exp(TOK_ERR, 0);
      push_exp(TOK_EOL, 0);
      push_exp(TOK_EOL, 0);
      push_exp(TOK_ERR, 0);
      push_exp(TOK_EOL, 0);
      push_exp(TOK_I, -5);
      push_exp(TOK_EOL, 0);
      send_string("X- \nX1..5\n\nJ\nI-0.05\n");
      wait_drain();

      // Consumer stall: token held stable, no bytes taken meanwhile.
      push_exp(TOK_X, 100);
      push_exp(TOK_Y, 200);
      push_exp(TOK_EOL, 0);
      out_ready = 1'b0;
      drv_done  = 1'b0;
      fork
         begin
            send_string("X1 Y2\n");
            drv_done = 1'b1;
         end
      join_none
      for (int n = 0; n < 100 && !out_valid; n++) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         check_value("stall_in_ready", longint'(in_ready), 0);
         check_value("stall_out_valid", longint'(out_valid), 1);
         check_value("stall_out_type", longint'(out_type), longint'(TOK_X));
         check_value("stall_out_value", longint'(out_value), 100);
         @(negedge clk);
      end
      out_ready = 1'b1;
      for (int n = 0; n < 300 && !drv_done; n++) @(negedge clk);
      check_value("stall_driver_done", longint'(drv_done), 1);
      wait_drain();

      // Reset mid-token discards the partial word.
      send_string("X12");
      reset = 1'b0;
      @(negedge clk);
      check_value("mid_rst_in_ready", longint'(in_ready), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_value("mid_rst_out_valid", longint'(out_valid), 0);
      check_value("mid_rst_out_type", longint'(out_type), longint'(TOK_ERR));
      push_exp(TOK_J, -100);
      push_exp(TOK_EOL, 0);
      send_string("J-1\n");
      wait_drain();

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcode_tokenizer.md
# gcode_tokenizer

Streaming G-code lexer. Consumes one ASCII byte per accepted handshake, classifies it through the existing character decoder, and accumulates signed fixed-point decimal numbers. Emits one token per word (letter + value) and one end-of-line token per line, over a valid/ready handshake. It sits between the byte source (UART/FIFO) and the command assembler that builds motion commands.

## Interface
Parameters:
- NUM_BITS, 32: width of signed token value (two's complement).
- FRAC_DIGITS, 2: decimal fraction digits kept; value = round-toward-zero(number × 10^FRAC_DIGITS).
- MAX_INT_DIGITS, 6: integer digits accepted before overflow error.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  byte available.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_type  out  Tok_t  token type: TOK_G, TOK_X, TOK_Y, TOK_I, TOK_J, TOK_F, TOK_EOL, TOK_ERR.
- out_value  out  NUM_BITS  signed scaled value; 0 for TOK_EOL/TOK_ERR.
- out_valid  out  1  token held stable until accepted.
- out_ready  in  1  consumer accepts on out_valid && out_ready.

## Operation
- States: IDLE, SIGN, INT, FRAC, EMIT, EMIT_EOL, SKIP.
- IDLE: space ignored; newline → EMIT_EOL; letter G/X/Y/I/J/F → latch type, clear accumulator → SIGN; anything else → error.
- SIGN: '-' → set neg, stay in INT-expect; digit → INT; other → error.
- INT: digit → acc = acc×10 + d, int_cnt++; '.' → FRAC; space → EMIT; newline → EMIT with eol_pending; other → error.
- FRAC: digit → if frac_cnt < FRAC_DIGITS then acc = acc×10 + d, frac_cnt++, else ignore; second '.' or other → error; space/newline as in INT.
- On leaving INT/FRAC: acc padded by ×10 per missing fraction digit (done in EMIT entry, may take FRAC_DIGITS−frac_cnt cycles), negated if neg.
- Error: no digit after letter, int_cnt > MAX_INT_DIGITS, acc > 2^(NUM_BITS−1)−1, illegal char → emit TOK_ERR, then SKIP.
- SKIP: discard bytes until newline; newline → EMIT_EOL.
- EMIT: out_valid high; on accept → EMIT_EOL if eol_pending else IDLE.
- EMIT_EOL: out_type TOK_EOL; on accept → IDLE.
- '-' alone then delimiter ("X- ") is error.

## Timing
- Reset: state IDLE, in_ready 0 during reset then 1, out_valid 0, out_type TOK_ERR, out_value 0, all counters/flags 0.
- in_ready = 1 only in IDLE, SIGN, INT, FRAC, SKIP; 0 in EMIT/EMIT_EOL and padding cycles.
- Byte accepted in cycle n updates state at edge n; token from delimiter at n is valid at n+1+(pad cycles).
- out_type/out_value stable while out_valid && !out_ready; out_valid drops the cycle after accept unless EOL follows (EMIT→EMIT_EOL gives back-to-back valid).
- Error token emitted the cycle after the offending byte; offending byte consumed (newline offender → TOK_ERR then TOK_EOL).
- Reset mid-token discards partial state; no token emitted.

## Structure
- Tok_t enum and TOK_* values in new Token_PKG; Char_t reused from Char_PKG.
- Character classification by instantiating the existing CharDecoder on in_data (combinational).
- Accumulator ×10 as shift-add ((acc<<3)+(acc<<1)+d) with overflow check on NUM_BITS+4 intermediate.

## Test plan
- "G1 X12.5 Y-3\n", FRAC_DIGITS=2, out_ready=1 → (G,100),(X,1250),(Y,−300),(EOL,0).
- "X0.129\n" → (X,12),(EOL); extra fraction digit ignored, no error.
- "X9999999\n" with MAX_INT_DIGITS=6 → (ERR,0),(EOL,0); following "Y1\n" → (Y,100),(EOL).
- "Q5 X1\n" → (ERR) at 'Q', rest of line skipped, then (EOL) only.
- out_ready held low 10 cycles on "X1 Y2\n" → in_ready 0 throughout, (X,100) stable, no byte lost; release → remaining tokens in order.
- Reset asserted after "X12" → no token; next "J-1\n" → (J,−100),(EOL).
